mmu_port_arbiter: RTL and testbench

Shares the single MMU memory port between the instruction-fetch stage and the load/store stage of the pipelined RV32I core. Both requesters use a hold-until-done handshake. The arbiter grants at most one request per cycle and drives the MMU's synchronous (1-cycle read latency) port. It then steers the returned read data and a one-cycle `done` strobe back to the owner. It sits between the core and `MMU` inside `rv32i_system`.

---
 rtl/mmu_port_arbiter_if.sv | 35 +++
 rtl/mmu_port_arbiter.sv | 68 ++++++
 tb/tb_mmu_port_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mmu_port_arbiter_if.sv
// Requester and MMU port bundle for mmu_port_arbiter.
// The slave modport is the arbiter's view; master is the core/MMU side.
interface mmu_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic [DATA_W-1:0]     if_rdata;
  logic                  if_done;
  logic                  d_req;
  logic                  d_we;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W/8-1:0]   d_wmask;
  logic [DATA_W-1:0]     d_rdata;
  logic                  d_done;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wr_data;
  logic                  mem_wr_ena;
  logic [DATA_W/8-1:0]   mem_wr_mask;
  logic [DATA_W-1:0]     mem_rd_data;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wmask, mem_rd_data,
    output if_rdata, if_done, d_rdata, d_done,
           mem_addr, mem_wr_data, mem_wr_ena, mem_wr_mask
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wmask, mem_rd_data,
    input  if_rdata, if_done, d_rdata, d_done,
           mem_addr, mem_wr_data, mem_wr_ena, mem_wr_mask
  );
endinterface

// File: rtl/mmu_port_arbiter.sv
// Shares one synchronous MMU port between fetch and load/store with a
// fixed data-first grant and a registered response-owner FSM.
module mmu_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic               clk,
  input logic               rst,
  mmu_port_arbiter_if.slave bus
);
  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, RESP_IF, RESP_D} state_t;

  state_t              state_q, state_d;
  logic                if_done_q, d_done_q;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                d_gnt, if_gnt;
  logic                wr_ena_d;
  logic [MASK_W-1:0]   wr_mask_d;
  logic [DATA_W-1:0]   wr_data_d;

  // A requester whose response is returning still holds req for that same
  // transaction, so it is excluded from the grant this cycle.
  always_comb begin
    d_gnt      = !rst && bus.d_req  && (state_q != RESP_D);
    if_gnt     = !rst && bus.if_req && (state_q != RESP_IF) && !d_gnt;
    state_d    = IDLE;
    mem_addr_d = mem_addr_q;
    wr_ena_d   = 1'b0;
    wr_mask_d  = '0;
    wr_data_d  = '0;
    if (d_gnt) begin
      state_d    = RESP_D;
      mem_addr_d = bus.d_addr;
      wr_ena_d   = bus.d_we;
      wr_mask_d  = bus.d_we ? bus.d_wmask : '0;
      wr_data_d  = bus.d_wdata;
    end else if (if_gnt) begin
      state_d    = RESP_IF;
      mem_addr_d = bus.if_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      if_done_q  <= (state_d == RESP_IF);
      d_done_q   <= (state_d == RESP_D);
      mem_addr_q <= mem_addr_d;
    end
  end

  // Gating with rst drops the response of a transaction granted just before reset.
  assign bus.if_done     = if_done_q && !rst;
  assign bus.d_done      = d_done_q && !rst;
  assign bus.if_rdata    = bus.mem_rd_data;
  assign bus.d_rdata     = bus.mem_rd_data;
  assign bus.mem_addr    = mem_addr_d;
  assign bus.mem_wr_ena  = wr_ena_d;
  assign bus.mem_wr_mask = wr_mask_d;
  assign bus.mem_wr_data = wr_data_d;
endmodule

// File: tb/tb_mmu_port_arbiter.sv
// Directed table-driven bench for mmu_port_arbiter plus contention and
// latency sequences.
module tb_mmu_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  mmu_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mmu_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, ifr;
    logic [31:0] ifa;
    logic        dr, we;
    logic [31:0] da, wd;
    logic [3:0]  wm;
    logic [31:0] rd;
    logic        eif, ed, ca;
    logic [31:0] ea;
    logic        ewe;
    logic [3:0]  emask;
    logic [31:0] ewd;
  } vec_t;

  vec_t tv[24];

  function automatic vec_t mk(logic r, logic ifr, logic [31:0] ifa, logic dr, logic we,
                              logic [31:0] da, logic [31:0] wd, logic [3:0] wm, logic [31:0] rd,
                              logic eif, logic ed, logic ca, logic [31:0] ea, logic ewe,
                              logic [3:0] emask, logic [31:0] ewd);
    vec_t v;
    v.rst = r; v.ifr = ifr; v.ifa = ifa; v.dr = dr; v.we = we; v.da = da; v.wd = wd;
    v.wm = wm; v.rd = rd; v.eif = eif; v.ed = ed; v.ca = ca; v.ea = ea; v.ewe = ewe;
    v.emask = emask; v.ewd = ewd;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got 0x%08h expected 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst         = v.rst;
    bus.if_req  = v.ifr;
    bus.if_addr = v.ifa;
    bus.d_req   = v.dr;
    bus.d_we    = v.we;
    bus.d_addr  = v.da;
    bus.d_wdata = v.wd;
    bus.d_wmask = v.wm;
    bus.mem_rd_data = v.rd;
  endtask

  initial begin
    int dcnt, icnt, both, lat;
    // Contention phase uses if_addr 0x40, d_addr 0x2000, load with full mask.
    tv[0]  = mk(1,1,32'h40,1,0,32'h2000,32'h1111_1111,4'hF,32'h0,        0,0,1,32'h0,   0,4'h0,32'h0);
    tv[1]  = mk(1,1,32'h40,1,0,32'h2000,32'h1111_1111,4'hF,32'h0,        0,0,1,32'h0,   0,4'h0,32'h0);
    tv[2]  = mk(0,1,32'h40,1,0,32'h2000,32'h1111_1111,4'hF,32'hC0DE_0002,0,0,1,32'h2000,0,4'h0,32'h1111_1111);
    tv[3]  = mk(0,1,32'h40,1,0,32'h2000,32'h1111_1111,4'hF,32'hC0DE_0003,0,1,1,32'h40,  0,4'h0,32'h0);
    tv[4]  = mk(0,1,32'h40,1,0,32'h2000,32'h1111_1111,4'hF,32'hC0DE_0004,1,0,1,32'h2000,0,4'h0,32'h1111_1111);
    tv[5]  = mk(0,1,32'h40,1,0,32'h2000,32'h1111_1111,4'hF,32'hC0DE_0005,0,1,1,32'h40,  0,4'h0,32'h0);
    tv[6]  = mk(0,1,32'h40,1,0,32'h2000,32'h1111_1111,4'hF,32'hC0DE_0006,1,0,1,32'h2000,0,4'h0,32'h1111_1111);
    tv[7]  = mk(0,1,32'h40,1,0,32'h2000,32'h1111_1111,4'hF,32'hC0DE_0007,0,1,1,32'h40,  0,4'h0,32'h0);
    tv[8]  = mk(0,1,32'h40,1,0,32'h2000,32'h1111_1111,4'hF,32'hC0DE_0008,1,0,1,32'h2000,0,4'h0,32'h1111_1111);
    tv[9]  = mk(0,1,32'h40,1,0,32'h2000,32'h1111_1111,4'hF,32'hC0DE_0009,0,1,1,32'h40,  0,4'h0,32'h0);
    tv[10] = mk(0,0,32'h40,0,0,32'h2000,32'h1111_1111,4'hF,32'hC0DE_000A,1,0,1,32'h40,  0,4'h0,32'h0);
    tv[11] = mk(0,0,32'h40,0,0,32'h2000,32'h0,        4'h0,32'h0,        0,0,1,32'h40,  0,4'h0,32'h0);
    // Lone fetch, then fetches overlapped with a data request during RESP_IF.
    tv[12] = mk(0,1,32'h10,0,0,32'h0,   32'h0,        4'h0,32'h0,        0,0,1,32'h10,  0,4'h0,32'h0);
    tv[13] = mk(0,1,32'h10,0,0,32'h0,   32'h0,        4'h0,32'h0051_3023,1,0,1,32'h10,  0,4'h0,32'h0);
    tv[14] = mk(0,1,32'h14,0,0,32'h0,   32'h0,        4'h0,32'h0,        0,0,1,32'h14,  0,4'h0,32'h0);
    tv[15] = mk(0,1,32'h18,1,0,32'h3000,32'h0,        4'hF,32'hC0DE_000F,1,0,1,32'h3000,0,4'h0,32'h0);
    tv[16] = mk(0,1,32'h18,1,0,32'h3000,32'h0,        4'hF,32'hC0DE_0010,0,1,1,32'h18,  0,4'h0,32'h0);
    // Store, then load with the same mask, then reset mid-load.
    tv[17] = mk(0,0,32'h18,1,1,32'h1004,32'hDEAD_BEEF,4'h3,32'hC0DE_0011,1,0,1,32'h1004,1,4'h3,32'hDEAD_BEEF);
    tv[18] = mk(0,0,32'h18,0,1,32'h1004,32'hDEAD_BEEF,4'h3,32'hC0DE_0012,0,1,1,32'h1004,0,4'h0,32'h0);
    tv[19] = mk(0,0,32'h18,1,0,32'h1008,32'h1234_5678,4'h3,32'h0,        0,0,1,32'h1008,0,4'h0,32'h1234_5678);
    tv[20] = mk(1,0,32'h18,1,0,32'h1008,32'h1234_5678,4'h3,32'hC0DE_0014,0,0,0,32'h0,   0,4'h0,32'h0);
    tv[21] = mk(0,0,32'h18,1,0,32'h1008,32'h1234_5678,4'h3,32'hC0DE_0015,0,0,1,32'h1008,0,4'h0,32'h1234_5678);
    tv[22] = mk(0,0,32'h18,0,0,32'h1008,32'h1234_5678,4'h3,32'hC0DE_0016,0,1,1,32'h1008,0,4'h0,32'h0);
    tv[23] = mk(0,0,32'h18,0,0,32'h1008,32'h0,        4'h0,32'h0,        0,0,1,32'h1008,0,4'h0,32'h0);

    drive(tv[0]);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      drive(tv[i]);
      #2;
      chk("if_done", i, 32'(bus.if_done), 32'(tv[i].eif));
      chk("d_done", i, 32'(bus.d_done), 32'(tv[i].ed));
      chk("mem_wr_ena", i, 32'(bus.mem_wr_ena), 32'(tv[i].ewe));
      chk("mem_wr_mask", i, 32'(bus.mem_wr_mask), 32'(tv[i].emask));
      chk("mem_wr_data", i, bus.mem_wr_data, tv[i].ewd);
      if (tv[i].ca) chk("mem_addr", i, bus.mem_addr, tv[i].ea);
      if (tv[i].eif) chk("if_rdata", i, bus.if_rdata, tv[i].rd);
      if (tv[i].ed && !tv[i].we) chk("d_rdata", i, bus.d_rdata, tv[i].rd);
    end

    // Eight cycles of continuous contention from IDLE: 4 pulses each, never together.
    dcnt = 0; icnt = 0; both = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      bus.if_req = (c < 8);
      bus.d_req  = (c < 8);
      bus.d_we   = 1'b0;
      #2;
      if (bus.d_done) dcnt++;
      if (bus.if_done) icnt++;
      if (bus.d_done && bus.if_done) both++;
    end
    chk("contend_d_done_cnt", 0, 32'(dcnt), 32'd4);
    chk("contend_if_done_cnt", 0, 32'(icnt), 32'd4);
    chk("contend_coincident", 0, 32'(both), 32'd0);

    // Lone fetch: done must follow the grant by exactly one cycle.
    @(negedge clk);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h80;
    #2;
    chk("lone_grant_addr", 0, bus.mem_addr, 32'h80);
    lat = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      #2;
      if (bus.if_done) begin
        lat = k;
        break;
      end
    end
    bus.if_req = 1'b0;
    chk("lone_fetch_latency", 0, 32'(lat), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
